// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//
// Multi-cycle control FSM for the MIPS datapath. Sequences one instruction
// (addu, subu, ori, lw, sw, beq, jal, jr, lui) over FETCH/DECODE/EXE/MEM/WB.
// It waits on ready handshakes from instruction and data memory, and uses the
// same mux-select encodings as the single-cycle datapath.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   opcode     IR[31:26] from the registered IR
//   funct      IR[5:0]
//   cmp_eq     GPR[rs]==GPR[rt], valid in EXE
//   IMReady    instruction word valid this cycle
//   DMReady    data memory access completes this cycle
//   IMReq      instruction fetch request
//   IRWr       load IR
//   PCWr       load PC from NPC
//   NPCOp      00 PC+4, 01 branch, 10 jal target, 11 GPR[rs]
//   GRFWr      register file write strobe
//   EXTOp      1 sign-extend, 0 zero-extend
//   ALUOp      00 add, 01 sub, 10 or
//   DMReq      data memory request
//   DMWr       data memory write (only with DMReq)
//   A3Sel      00 rd, 01 rt, 10 $31
//   WDSel      00 ALU, 01 DM, 10 PC+4, 11 imm<<16
//   BSel       1 ALU B = EXT output, 0 GPR[rt]
//   state      current state, for debug
//   instr_cnt  retired instruction count (one per PCWr cycle)
// ---------------------------------------------------------------------------
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             cmp_eq,
    input  logic             IMReady,
    input  logic             DMReady,
    output logic             IMReq,
    output logic             IRWr,
    output logic             PCWr,
    output logic [1:0]       NPCOp,
    output logic             GRFWr,
    output logic             EXTOp,
    output logic [1:0]       ALUOp,
    output logic             DMReq,
    output logic             DMWr,
    output logic [1:0]       A3Sel,
    output logic [1:0]       WDSel,
    output logic             BSel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;

    // Instruction decode from the registered IR fields
    logic r_type;
    logic is_addu, is_subu, is_jr, is_ori, is_lw, is_sw, is_beq, is_jal, is_lui, is_nop;

    assign r_type  = (opcode == 6'b000000);
    assign is_addu = r_type && (funct == 6'b100001);
    assign is_subu = r_type && (funct == 6'b100011);
    assign is_jr   = r_type && (funct == 6'b001000);
    assign is_ori  = (opcode == 6'b001101);
    assign is_lw   = (opcode == 6'b100011);
    assign is_sw   = (opcode == 6'b101011);
    assign is_beq  = (opcode == 6'b000100);
    assign is_jal  = (opcode == 6'b000011);
    assign is_lui  = (opcode == 6'b001111);
    assign is_nop  = !(is_addu || is_subu || is_jr || is_ori || is_lw ||
                       is_sw || is_beq || is_jal || is_lui);

    // Next-state logic; illegal encodings fall back to FETCH
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = IMReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_jr || is_nop)
                    state_next = S_FETCH;
                else if (is_jal)
                    state_next = S_WB;
                else
                    state_next = S_EXE;
            end
            S_EXE: begin
                if (is_beq)
                    state_next = S_FETCH;
                else if (is_lw || is_sw)
                    state_next = S_MEM;
                else
                    state_next = S_WB;
            end
            S_MEM: begin
                if (!DMReady)
                    state_next = S_MEM;
                else if (is_sw)
                    state_next = S_FETCH;
                else
                    state_next = S_WB;
            end
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // Strobes and selects follow the current state and the ready inputs so
    // the memories see a request in the same cycle it is owned. Holding
    // reset low forces everything to zero without waiting for an edge.
    always_comb begin
        IMReq = 1'b0;
        IRWr  = 1'b0;
        PCWr  = 1'b0;
        NPCOp = 2'b00;
        GRFWr = 1'b0;
        DMReq = 1'b0;
        DMWr  = 1'b0;
        EXTOp = 1'b0;
        ALUOp = 2'b00;
        A3Sel = 2'b00;
        WDSel = 2'b00;
        BSel  = 1'b0;
        if (reset) begin
            // Mode selects are held for the whole instruction once IR is valid
            if (state_reg == S_DECODE || state_reg == S_EXE ||
                state_reg == S_MEM    || state_reg == S_WB) begin
                if (is_ori)
                    ALUOp = 2'b10;
                else if (is_subu || is_beq)
                    ALUOp = 2'b01;
                EXTOp = is_lw || is_sw;
                BSel  = is_ori || is_lw || is_sw;
                if (is_jal)
                    A3Sel = 2'b10;
                else if (is_ori || is_lw || is_lui)
                    A3Sel = 2'b01;
                if (is_jal)
                    WDSel = 2'b10;
                else if (is_lui)
                    WDSel = 2'b11;
                else if (is_lw)
                    WDSel = 2'b01;
            end
            case (state_reg)
                S_FETCH: begin
                    IMReq = 1'b1;
                    IRWr  = IMReady;
                end
                S_DECODE: begin
                    if (is_jr) begin
                        PCWr  = 1'b1;
                        NPCOp = 2'b11;
                    end else if (is_nop) begin
                        PCWr  = 1'b1;
                    end
                end
                S_EXE: begin
                    if (is_beq) begin
                        PCWr  = 1'b1;
                        NPCOp = cmp_eq ? 2'b01 : 2'b00;
                    end
                end
                S_MEM: begin
                    DMReq = 1'b1;
                    DMWr  = is_sw;
                    PCWr  = is_sw && DMReady;
                end
                S_WB: begin
                    GRFWr = 1'b1;
                    PCWr  = 1'b1;
                    NPCOp = is_jal ? 2'b10 : 2'b00;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (PCWr)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign state     = state_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
//
// Directed bench for mc_controller: runs individual instructions with chosen
// memory wait counts, records what the controller did over the instruction
// and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        cmp_eq;
    logic        IMReady;
    logic        DMReady;
    logic        IMReq, IRWr, PCWr, GRFWr, EXTOp, DMReq, DMWr, BSel;
    logic [1:0]  NPCOp, ALUOp, A3Sel, WDSel;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    mc_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .cmp_eq(cmp_eq), .IMReady(IMReady), .DMReady(DMReady),
        .IMReq(IMReq), .IRWr(IRWr), .PCWr(PCWr), .NPCOp(NPCOp),
        .GRFWr(GRFWr), .EXTOp(EXTOp), .ALUOp(ALUOp), .DMReq(DMReq),
        .DMWr(DMWr), .A3Sel(A3Sel), .WDSel(WDSel), .BSel(BSel),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observations captured by run_instr
    int         r_cycles, r_dmreq, r_dmwr, r_grf, r_ovl;
    logic [2:0] r_pc_state;
    logic [1:0] r_npc, r_a3, r_wd, r_alu;
    logic       r_bsel, r_ext;
    int         ovl_total = 0;

    // Runs one instruction from FETCH until the PCWr cycle. Called at
    // posedge+1 with the DUT in FETCH; returns at posedge+1 after retirement.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic eq, input int imw, input int dmw);
        bit done = 0;
        int mw = 0;
        opcode = op; funct = fn; cmp_eq = eq;
        r_cycles = 0; r_dmreq = 0; r_dmwr = 0; r_grf = 0; r_ovl = 0;
        r_pc_state = 3'd7; r_npc = 2'b00; r_a3 = 2'b00; r_wd = 2'b00;
        r_alu = 2'b00; r_bsel = 0; r_ext = 0;
        while (!done && r_cycles < 40) begin
            IMReady = (r_cycles >= imw);
            if (state == 3'd3) begin
                DMReady = (mw >= dmw);
                mw++;
            end else begin
                DMReady = 1'b1;   // ignored outside MEM
            end
            #1;
            r_cycles++;
            if (DMReq) r_dmreq++;
            if (DMWr)  r_dmwr++;
            if (GRFWr) r_grf++;
            if (IRWr && PCWr) r_ovl++;
            if (PCWr) begin
                done = 1;
                r_pc_state = state; r_npc = NPCOp; r_a3 = A3Sel;
                r_wd = WDSel; r_alu = ALUOp; r_bsel = BSel; r_ext = EXTOp;
            end
            @(posedge clk); #1;
        end
        if (!done) check("timeout", 32'(r_cycles), 32'd0);
        ovl_total += r_ovl;
        $display("instr op=%b fn=%b eq=%0d imw=%0d dmw=%0d: cycles=%0d dmreq=%0d dmwr=%0d grf=%0d npc=%b cnt=%0d",
                 op, fn, eq, imw, dmw, r_cycles, r_dmreq, r_dmwr, r_grf, r_npc, instr_cnt);
    endtask

    initial begin
        reset = 1'b0; opcode = 6'd0; funct = 6'd0; cmp_eq = 1'b0;
        IMReady = 1'b1; DMReady = 1'b0;

        // Reset held for 3 cycles with IMReady high
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", {26'd0, IMReq, IRWr, PCWr, GRFWr, DMReq, DMWr}, 32'd0);
        check("rst_sel", {22'd0, NPCOp, ALUOp, A3Sel, WDSel, EXTOp, BSel}, 32'd0);
        check("rst_cnt", instr_cnt, 32'd0);
        reset = 1'b1;
        IMReady = 1'b0;
        #1;
        check("rel_imreq", 32'(IMReq), 32'd1);
        @(posedge clk); #1;
        check("wait_state", 32'(state), 32'd0);

        // addu
        run_instr(6'b000000, 6'b100001, 0, 0, 0);
        check("addu_cyc", r_cycles, 4);
        check("addu_sel", {r_a3, r_wd, r_alu}, {2'b00, 2'b00, 2'b00});
        check("addu_grf", r_grf, 1);
        check("addu_pcst", 32'(r_pc_state), 32'd4);
        // ori
        run_instr(6'b001101, 6'b000000, 0, 0, 0);
        check("ori_cyc", r_cycles, 4);
        check("ori_sel", {r_a3, r_alu, r_bsel, r_ext}, {2'b01, 2'b10, 1'b1, 1'b0});
        // lui
        run_instr(6'b001111, 6'b000000, 0, 0, 0);
        check("lui_cyc", r_cycles, 4);
        check("lui_wd", 32'(r_wd), 32'b11);
        // jal
        run_instr(6'b000011, 6'b000000, 0, 0, 0);
        check("jal_cyc", r_cycles, 3);
        check("jal_sel", {r_a3, r_wd, r_npc}, {2'b10, 2'b10, 2'b10});
        check("jal_grf", r_grf, 1);
        // jr
        run_instr(6'b000000, 6'b001000, 0, 0, 0);
        check("jr_cyc", r_cycles, 2);
        check("jr_npc", 32'(r_npc), 32'b11);
        check("jr_pcst", 32'(r_pc_state), 32'd1);
        check("jr_grf", r_grf, 0);
        check("cnt5", instr_cnt, 32'd5);

        // lw with 3 DM wait cycles
        run_instr(6'b100011, 6'b000000, 0, 0, 3);
        check("lw_cyc", r_cycles, 8);
        check("lw_dmreq", r_dmreq, 4);
        check("lw_dmwr", r_dmwr, 0);
        check("lw_grf", r_grf, 1);
        check("lw_sel", {r_wd, r_ext}, {2'b01, 1'b1});
        // sw with 2 DM wait cycles
        run_instr(6'b101011, 6'b000000, 0, 0, 2);
        check("sw_cyc", r_cycles, 6);
        check("sw_dmreq", r_dmreq, 3);
        check("sw_dmwr", r_dmwr, 3);
        check("sw_grf", r_grf, 0);
        check("sw_pcst", 32'(r_pc_state), 32'd3);
        // beq taken / not taken
        run_instr(6'b000100, 6'b000000, 1, 0, 0);
        check("beq1_cyc", r_cycles, 3);
        check("beq1_npc", 32'(r_npc), 32'b01);
        check("beq1_pcst", 32'(r_pc_state), 32'd2);
        check("beq1_alu", 32'(r_alu), 32'b01);
        run_instr(6'b000100, 6'b000000, 0, 0, 0);
        check("beq0_npc", 32'(r_npc), 32'b00);
        check("beq0_grf", r_grf, 0);
        // unknown opcode -> NOP
        run_instr(6'b111111, 6'b000000, 0, 0, 0);
        check("nop_cyc", r_cycles, 2);
        check("nop_npc", 32'(r_npc), 32'b00);
        check("nop_grfdm", r_grf + r_dmwr, 0);
        // subu with 2 IM wait cycles
        run_instr(6'b000000, 6'b100011, 0, 2, 0);
        check("subu_cyc", r_cycles, 6);
        check("subu_alu", 32'(r_alu), 32'b01);
        check("cnt11", instr_cnt, 32'd11);
        check("irwr_pcwr", ovl_total, 0);

        // Reset in MEM of a sw while waiting on DMReady
        opcode = 6'b101011; funct = 6'd0; IMReady = 1'b1; DMReady = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mem_state", 32'(state), 32'd3);
        check("mem_dmreq", {31'd0, DMReq & DMWr}, 32'd1);
        reset = 1'b0;
        #1;
        check("rstmem_strb", {29'd0, DMReq, DMWr, PCWr}, 32'd0);
        @(posedge clk); #1;
        check("rstmem_state", 32'(state), 32'd0);
        check("rstmem_cnt", instr_cnt, 32'd0);
        reset = 1'b1;
        $display("reset-in-MEM: state=%0d cnt=%0d", state, instr_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control FSM for the MIPS datapath: it sequences one instruction (addu, subu, ori, lw, sw, beq, jal, jr, lui) over FETCH/DECODE/EXE/MEM/WB states. It waits on ready handshakes from instruction and data memory, and asserts write strobes only in the state that owns them. It keeps the single-cycle datapath's mux-select encodings, so GRF, ALU, EXT, DM and NPC are reused unchanged. It sits between the IR/PC registers and the datapath muxes, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  6  IR[31:26] (registered IR)
- funct  in  6  IR[5:0]
- cmp_eq  in  1  GPR[rs]==GPR[rt], valid in EXE
- IMReady  in  1  instruction word valid this cycle
- DMReady  in  1  DM access completes this cycle
- IMReq  out  1  instruction fetch request
- IRWr  out  1  load IR
- PCWr  out  1  load PC from NPC
- NPCOp  out  2  00 PC+4, 01 branch target, 10 jal target, 11 GPR[rs]
- GRFWr  out  1  register file write strobe
- EXTOp  out  1  1 sign-extend, 0 zero-extend
- ALUOp  out  2  00 add, 01 sub, 10 or
- DMReq  out  1  data memory request
- DMWr  out  1  data memory write (only with DMReq)
- A3Sel  out  2  00 rd, 01 rt, 10 $31
- WDSel  out  2  00 ALU, 01 DM, 10 PC+4, 11 imm<<16
- BSel  out  1  1 ALU B = EXT output, 0 GPR[rt]
- state  out  3  current state, for debug
- instr_cnt  out  CNT_W  retired instruction count

## Operation
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Values 5–7 are illegal and go to FETCH on the next edge.
- Decode, from the registered opcode/funct:
  - R-type (opcode 000000): addu funct 100001, subu 100011, jr 001000.
  - I/J-type by opcode: ori 001101, lw 100011, sw 101011, beq 000100, jal 000011, lui 001111.
  - Anything else is a NOP.
- FETCH:
  - IMReq=1, IRWr=IMReady.
  - IMReady=1 → DECODE; otherwise stay.
- DECODE:
  - jr: PCWr=1, NPCOp=11 → FETCH.
  - jal: → WB.
  - NOP: PCWr=1, NPCOp=00 → FETCH.
  - Others: → EXE.
- EXE:
  - beq: PCWr=1, NPCOp = cmp_eq ? 01 : 00 → FETCH.
  - lw/sw: → MEM.
  - addu/subu/ori/lui: → WB.
- MEM:
  - DMReq=1; DMWr=1 for sw.
  - Stay until DMReady.
  - On DMReady: sw does PCWr=1, NPCOp=00 → FETCH; lw → WB.
- WB:
  - GRFWr=1, PCWr=1 → FETCH.
  - NPCOp=10 for jal, 00 otherwise.
- Select/mode outputs depend only on the decoded instruction and are held in every state after FETCH:
  - ALUOp: ori=10, subu/beq=01, else 00.
  - EXTOp = lw|sw.
  - BSel = ori|lw|sw.
  - A3Sel: jal=10, ori/lw/lui=01, else 00.
  - WDSel: jal=10, lui=11, lw=01, else 00.
- Strobes (IRWr, PCWr, GRFWr, DMWr, DMReq, IMReq) are asserted only as listed above; they are 0 in every other state.
- instr_cnt increments by 1 on each cycle with PCWr=1, wrapping modulo 2^CNT_W.

## Timing
- Reset (reset=0 sampled at an edge), from any state including mid-wait in FETCH or MEM:
  - state=FETCH, instr_cnt=0.
  - While reset=0, all strobes are forced to 0 combinationally. NPCOp, ALUOp, A3Sel, WDSel = 00; EXTOp, BSel = 0.
- Cycle counts with zero wait:
  - jr/NOP: 2
  - beq/jal: 3
  - R-type/ori/lui/sw: 4
  - lw: 5
  - Each cycle IMReady or DMReady is low adds exactly 1 cycle.
- Handshakes:
  - IMReq stays high, and DMReq/DMWr stay stable, until the ready input is sampled high.
  - Ready sampled high in any state that is not waiting on it is ignored.
- PCWr is asserted for exactly one cycle per instruction, in that instruction's last state.
- GRFWr is at most one cycle per instruction, and that cycle is also the PCWr cycle.
- IRWr and PCWr are never high in the same cycle.

## Test plan
- Reset: hold reset=0 for 3 cycles with IMReady=1 → state=0, every strobe 0, instr_cnt=0. Release → IMReq=1 on the next cycle.
- Sequence addu, ori, lui, jal, jr with IMReady/DMReady tied high:
  - Cycle counts 4, 4, 4, 3, 2.
  - WB selects: addu A3Sel=00 WDSel=00 ALUOp=00; ori A3Sel=01 ALUOp=10 BSel=1 EXTOp=0; lui WDSel=11; jal A3Sel=10 WDSel=10 NPCOp=10.
  - jr: NPCOp=11 in DECODE.
  - instr_cnt=5 at the end.
- lw with DMReady low for 3 MEM cycles:
  - DMReq held 4 cycles, DMWr=0.
  - Then WB with GRFWr=1, WDSel=01, EXTOp=1; 8 cycles total.
- sw with DMReady delayed 2 cycles → DMReq=DMWr=1 for 3 cycles, then PCWr, GRFWr never 1, 6 cycles total.
- beq twice:
  - cmp_eq=1 → NPCOp=01, PCWr in EXE, ALUOp=01.
  - cmp_eq=0 → NPCOp=00.
  - Unknown opcode 111111 → 2 cycles, NPCOp=00, no GRFWr/DMWr.
- Reset asserted in MEM of a sw while waiting on DMReady → DMReq/DMWr drop to 0 in that cycle, state=FETCH after the edge, instr_cnt=0, no PCWr.
